// File: rtl/mips_mc_control_pkg.sv
// mips_ctrl_pkg: opcode/funct encodings, ALU codes, FSM states and decode bundle for mips_mc_control
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ, C_ILL} cls_t;
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       mem_to_reg;
  } ctrl_t;
endpackage

// File: rtl/mips_mc_control_if.sv
// mips_mc_control_if: fetch/datapath <-> control unit bundle; carries illegal when MC_ILLEGAL_TRAP_EN is defined
interface mips_mc_control_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] Inst;
  logic        mem_ready;
  logic        zero;
  logic        RegDst;
  logic        RegWrite;
  logic        ALUSrc;
  logic [2:0]  ALUctrl;
  logic        MemWrite;
  logic        MemRead;
  logic        MemToReg;
  logic        branch_taken;
  logic        instr_done;
  logic        mem_abort;
`ifdef MC_ILLEGAL_TRAP_EN
  logic        illegal;
`endif
  modport slave (
    input  inst_valid, Inst, mem_ready, zero,
`ifdef MC_ILLEGAL_TRAP_EN
    output illegal,
`endif
    output inst_ready, RegDst, RegWrite, ALUSrc, ALUctrl, MemWrite, MemRead, MemToReg,
    output branch_taken, instr_done, mem_abort
  );
  modport master (
    output inst_valid, Inst, mem_ready, zero,
`ifdef MC_ILLEGAL_TRAP_EN
    input  illegal,
`endif
    input  inst_ready, RegDst, RegWrite, ALUSrc, ALUctrl, MemWrite, MemRead, MemToReg,
    input  branch_taken, instr_done, mem_abort
  );
endinterface

// File: rtl/mips_mc_control_decode.sv
// mips_mc_decode: combinational opcode/funct decode into static controls, instruction class and illegal flag
module mips_mc_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output ctrl_t      ctrl,
  output cls_t       cls,
  output logic       illegal
);
  logic [2:0] r_alu;
  logic       r_ok;
  // classify the instruction and derive the controls held for its lifetime
  always_comb begin
    r_alu = fn == FN_ADD ? ALU_ADD : fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND :
            fn == FN_OR ? ALU_OR : ALU_SLT;
    r_ok = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    cls = op == OP_RTYPE ? (r_ok ? C_RTYPE : C_ILL) : op == OP_LW ? C_LW : op == OP_SW ? C_SW :
          op == OP_ADDI ? C_ADDI : op == OP_BEQ ? C_BEQ : C_ILL;
    illegal = cls == C_ILL;
    ctrl.reg_dst = cls == C_RTYPE;
    ctrl.alu_src = cls inside {C_LW, C_SW, C_ADDI};
    ctrl.alu_ctrl = cls == C_RTYPE ? r_alu : cls == C_BEQ ? ALU_SUB : ALU_ADD;
    ctrl.mem_to_reg = cls == C_LW;
  end
endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS control FSM (IDLE/DECODE/EXEC/MEM/WB); MC_ILLEGAL_TRAP_EN halts on illegal instructions
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  mips_mc_control_if.slave bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 2);
`ifdef MC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  state_t          state_q, state_d;
  logic [31:0]     ir_q, ir_d;
  cls_t            cls_q, cls_d, dec_cls;
  ctrl_t           ctrl_q, ctrl_d, dec_ctrl;
  logic            dec_ill;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            abort_q, abort_d, halt_q, halt_d;
  logic            accept, timeout;
  mips_mc_decode u_dec (
    .op     (ir_d[31:26]),
    .fn     (ir_d[5:0]),
    .ctrl   (dec_ctrl),
    .cls    (dec_cls),
    .illegal(dec_ill)
  );
  // next-state, IR capture and MEM wait counting; controls latch on accept and clear on return to IDLE
  always_comb begin
    accept = bus.inst_valid && bus.inst_ready;
    ir_d = accept ? bus.Inst : ir_q;
    timeout = MEM_TIMEOUT != 0 && !bus.mem_ready && cnt_q == CW'(MEM_TIMEOUT - 1);
    state_d = state_q;
    cls_d = cls_q;
    ctrl_d = ctrl_q;
    cnt_d = '0;
    abort_d = 1'b0;
    halt_d = halt_q;
    case (state_q)
      S_IDLE: begin
        state_d = accept ? S_DECODE : S_IDLE;
        cls_d = accept ? dec_cls : cls_q;
        ctrl_d = accept ? (dec_ill ? ctrl_t'(0) : dec_ctrl) : ctrl_q;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = cls_q inside {C_LW, C_SW} ? S_MEM : cls_q inside {C_RTYPE, C_ADDI} ? S_WB : S_IDLE;
        halt_d = halt_q || (TRAP && cls_q == C_ILL);
      end
      S_MEM: begin
        state_d = bus.mem_ready ? (cls_q == C_LW ? S_WB : S_IDLE) : timeout ? S_IDLE : S_MEM;
        abort_d = timeout;
        cnt_d = cnt_q + 1'b1;
      end
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ctrl_d = state_d == S_IDLE ? ctrl_t'(0) : ctrl_d;
  end
  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q <= '0;
      cls_q <= C_RTYPE;
      ctrl_q <= '0;
      cnt_q <= '0;
      abort_q <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      cls_q <= cls_d;
      ctrl_q <= ctrl_d;
      cnt_q <= cnt_d;
      abort_q <= abort_d;
      halt_q <= halt_d;
    end
  end
  assign bus.inst_ready = state_q == S_IDLE && !halt_q;
  assign bus.RegDst = ctrl_q.reg_dst;
  assign bus.ALUSrc = ctrl_q.alu_src;
  assign bus.ALUctrl = ctrl_q.alu_ctrl;
  assign bus.MemToReg = ctrl_q.mem_to_reg;
  assign bus.RegWrite = state_q == S_WB;
  assign bus.MemRead = state_q == S_MEM && cls_q == C_LW;
  assign bus.MemWrite = state_q == S_MEM && cls_q == C_SW;
  assign bus.branch_taken = state_q == S_EXEC && cls_q == C_BEQ && bus.zero;
  assign bus.instr_done = state_q == S_WB || (state_q == S_EXEC && cls_q inside {C_BEQ, C_ILL}) ||
                          (state_q == S_MEM && cls_q == C_SW && bus.mem_ready);
  assign bus.mem_abort = abort_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal = halt_q;
`endif
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: randomized scoreboard bench for mips_mc_control against a per-instruction reference model
module tb_mips_mc_control;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  mips_mc_control_if bus ();
  mips_mc_control #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int lat;
    bit abort;
    bit mem;
    int ctl;
    int mr, mw, rw, bt;
  } exp_t;
  exp_t sb[$];
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int outs();
    return int'({bus.RegDst, bus.RegWrite, bus.ALUSrc, bus.ALUctrl, bus.MemWrite, bus.MemRead,
                 bus.MemToReg, bus.branch_taken, bus.instr_done, bus.mem_abort});
  endfunction
  function automatic exp_t model(logic [31:0] i, int w, bit z);
    exp_t e;
    string k;
    logic [2:0] alu;
    logic [5:0] op, fn;
    e = '{default: 0};
    op = i[31:26];
    fn = i[5:0];
    k = "ill";
    alu = 3'd0;
    if (op == 6'h00) begin
      if (fn == 6'h20) begin k = "r"; alu = 3'b101; end
      else if (fn == 6'h22) begin k = "r"; alu = 3'b110; end
      else if (fn == 6'h24) begin k = "r"; alu = 3'b000; end
      else if (fn == 6'h25) begin k = "r"; alu = 3'b001; end
      else if (fn == 6'h2a) begin k = "r"; alu = 3'b111; end
    end
    else if (op == 6'h23) k = "lw";
    else if (op == 6'h2b) k = "sw";
    else if (op == 6'h08) k = "addi";
    else if (op == 6'h04) k = "beq";
    if (k == "r") begin e.ctl = int'({1'b1, 1'b0, alu, 1'b0}); e.lat = 3; e.rw = 1; end
    else if (k == "addi") begin e.ctl = int'({1'b0, 1'b1, 3'b101, 1'b0}); e.lat = 3; e.rw = 1; end
    else if (k == "beq") begin e.ctl = int'({1'b0, 1'b0, 3'b110, 1'b0}); e.lat = 2; e.bt = int'(z); end
    else if (k == "ill") e.lat = 2;
    else begin
      e.mem = 1'b1;
      e.abort = w >= TO;
      if (k == "lw") begin
        e.ctl = int'({1'b0, 1'b1, 3'b101, 1'b1});
        e.lat = e.abort ? 3 + TO : 4 + w;
        e.mr = e.abort ? TO : w + 1;
        e.rw = e.abort ? 0 : 1;
      end else begin
        e.ctl = int'({1'b0, 1'b1, 3'b101, 1'b0});
        e.lat = e.abort ? 3 + TO : 3 + w;
        e.mw = e.abort ? TO : w + 1;
      end
    end
    return e;
  endfunction
  function automatic logic [31:0] rand_inst(int kind);
    logic [31:0] r;
    logic [5:0] op, fn;
    logic [5:0] fns[5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    r = $urandom();
    fn = r[5:0];
    op = 6'h00;
    case (kind)
      0: fn = fns[$urandom_range(0, 4)];
      1: op = 6'h08;
      2: op = 6'h23;
      3: op = 6'h2b;
      4: op = 6'h04;
      5: while (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) fn = 6'($urandom());
      default: begin
        op = 6'($urandom());
        while (op inside {6'h00, 6'h08, 6'h23, 6'h2b, 6'h04}) op = 6'($urandom());
      end
    endcase
    return {op, r[25:6], fn};
  endfunction
  // monitor: counts cycles since accept, checks held controls and strobe totals, pops at retire/abort
  bit busy = 1'b0;
  int cyc, mr, mw, rw, bt;
  exp_t e;
  bit fin;
  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
      sb.delete();
    end else begin
      if (busy) begin
        cyc++;
        e = sb[0];
        fin = bus.instr_done || bus.mem_abort;
        if (!(fin && e.abort))
          chk("static_ctl", int'({bus.RegDst, bus.ALUSrc, bus.ALUctrl, bus.MemToReg}), e.ctl);
        mr += int'(bus.MemRead);
        mw += int'(bus.MemWrite);
        rw += int'(bus.RegWrite);
        bt += int'(bus.branch_taken);
        if (fin || cyc >= 40) begin
          chk("latency", cyc, e.lat);
          chk("mem_abort", int'(bus.mem_abort), int'(e.abort));
          chk("instr_done", int'(bus.instr_done), int'(!e.abort));
          chk("memread_cycles", mr, e.mr);
          chk("memwrite_cycles", mw, e.mw);
          chk("regwrite_cycles", rw, e.rw);
          chk("branch_taken_pulses", bt, e.bt);
          void'(sb.pop_front());
          busy = 1'b0;
        end
      end else chk("idle_outputs", outs(), 0);
      if (bus.inst_valid && bus.inst_ready) begin
        if (sb.size() == 0) chk("scoreboard_empty_on_accept", 0, 1);
        else begin
          busy = 1'b1;
          cyc = 0; mr = 0; mw = 0; rw = 0; bt = 0;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(logic [31:0] inst, int w, bit z);
    exp_t x;
    int n;
    x = model(inst, w, z);
    n = 0;
    while (!bus.inst_ready && n < 60) begin tick(); n++; end
    if (!bus.inst_ready) begin
      chk("inst_ready_wait", 0, 1);
      return;
    end
    sb.push_back(x);
    bus.Inst = inst;
    bus.zero = z;
    bus.inst_valid = 1'b1;
    tick();
    bus.inst_valid = 1'b0;
    bus.Inst = $urandom();
    if (x.mem && !x.abort) begin
      repeat (2 + w) tick();
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
  initial begin
    int kind, sel, w, n;
    bus.inst_valid = 1'b0;
    bus.Inst = '0;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 0);
    chk("reset_inst_ready", int'(bus.inst_ready), 1);
    tick();
    rst = 1'b0;
    tick();
    issue(32'h00430820, 0, 1'b0);
    issue(32'h8c410000, 1, 1'b0);
    issue(32'hac410000, 0, 1'b1);
    issue(32'h10430004, 0, 1'b1);
    issue(32'h10430004, 0, 1'b0);
    issue(32'hac410000, 15, 1'b0);
    issue(32'h8c410000, 20, 1'b0);
    issue(32'hac410000, 20, 1'b0);
`ifndef MC_ILLEGAL_TRAP_EN
    issue(32'hfc000000, 0, 1'b0);
`endif
    for (int i = 0; i < 60; i++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      kind = $urandom_range(0, 4);
`else
      kind = $urandom_range(0, 6);
`endif
      sel = $urandom_range(0, 9);
      w = sel == 0 ? 20 : sel == 1 ? 15 : $urandom_range(0, 3);
      issue(rand_inst(kind), w, 1'($urandom_range(0, 1)));
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin tick(); n++; end
    chk("scoreboard_drain", sb.size(), 0);
    issue(32'hac410000, 99, 1'b0);
    repeat (4) tick();
    chk("mid_mem_memwrite", int'(bus.MemWrite), 1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_mem_reset_outputs", outs(), 0);
    chk("mid_mem_reset_inst_ready", int'(bus.inst_ready), 1);
    tick();
    rst = 1'b0;
    tick();
`ifdef MC_ILLEGAL_TRAP_EN
    issue(32'hfc000000, 0, 1'b0);
    repeat (5) tick();
    chk("trap_illegal", int'(bus.illegal), 1);
    chk("trap_inst_ready", int'(bus.inst_ready), 0);
    rst = 1'b1;
    tick();
    chk("trap_cleared_illegal", int'(bus.illegal), 0);
    chk("trap_cleared_inst_ready", int'(bus.inst_ready), 1);
    rst = 1'b0;
    tick();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
